acondicionador_lanzar: RTL

- Front end that turns raw, bouncing, asynchronous player push-buttons into the clean `lanzar` launch signals consumed by the dice-game core.
- It synchronises each button, debounces it with a per-channel stability counter and FSM, and drives:
  - a debounced level for the core's `lanzar_pi[N-1:0]` input;
  - a one-cycle press pulse per player.
- It sits between the board buttons and the game core, one channel per player.

---
 rtl/acondicionador_lanzar.sv | 118 +++++++++++
 1 files changed

// File: rtl/acondicionador_lanzar.sv
// Button conditioner for the dice game: per-player 2-flop synchroniser, stability-counter
// debounce FSM, registered debounced level (lanzar_po) and one-cycle press pulse (pulso_po).
module acondicionador_lanzar #(
    parameter int N_JUGADORES    = 2,
    parameter int CICLOS_ESTABLE = 1_000_000
) (
    input  logic                   clk_pi,
    input  logic                   rst_n_pi,
    input  logic [N_JUGADORES-1:0] botones_pi,
    output logic [N_JUGADORES-1:0] lanzar_po,
    output logic [N_JUGADORES-1:0] pulso_po
);

    localparam int CW = $clog2(CICLOS_ESTABLE + 1);
    localparam logic [CW-1:0] CNT_ULTIMO = CW'(CICLOS_ESTABLE - 1);

    typedef enum logic [1:0] {
        SUELTO      = 2'd0,
        VALIDA_PRES = 2'd1,
        PRESIONADO  = 2'd2,
        VALIDA_LIB  = 2'd3
    } estado_t;

    // The raw buttons are asynchronous; only s_q is ever looked at by the FSMs.
    logic [N_JUGADORES-1:0] s1_q;
    logic [N_JUGADORES-1:0] s_q;

    always_ff @(posedge clk_pi) begin
        if (!rst_n_pi) begin
            s1_q <= '0;
            s_q  <= '0;
        end else begin
            s1_q <= botones_pi;
            s_q  <= s1_q;
        end
    end

    for (genvar g = 0; g < N_JUGADORES; g++) begin : g_canal
        estado_t       estado_q, estado_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lanzar_q, lanzar_d;
        logic          pulso_q, pulso_d;

        always_ff @(posedge clk_pi) begin
            if (!rst_n_pi) begin
                estado_q <= SUELTO;
                cnt_q    <= '0;
                lanzar_q <= 1'b0;
                pulso_q  <= 1'b0;
            end else begin
                estado_q <= estado_d;
                cnt_q    <= cnt_d;
                lanzar_q <= lanzar_d;
                pulso_q  <= pulso_d;
            end
        end

        always_comb begin
            estado_d = estado_q;
            cnt_d    = cnt_q;
            lanzar_d = lanzar_q;
            pulso_d  = 1'b0;
            unique case (estado_q)
                SUELTO: begin
                    lanzar_d = 1'b0;
                    if (s_q[g]) begin
                        estado_d = VALIDA_PRES;
                        cnt_d    = CW'(1);
                    end else begin
                        cnt_d    = '0;
                    end
                end
                VALIDA_PRES: begin
                    if (!s_q[g]) begin
                        estado_d = SUELTO;
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_ULTIMO) begin
                        estado_d = PRESIONADO;
                        cnt_d    = '0;
                        lanzar_d = 1'b1;
                        pulso_d  = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
                PRESIONADO: begin
                    lanzar_d = 1'b1;
                    if (!s_q[g]) begin
                        estado_d = VALIDA_LIB;
                        cnt_d    = CW'(1);
                    end
                end
                VALIDA_LIB: begin
                    // A short release returns to PRESIONADO silently: no second pulse.
                    if (s_q[g]) begin
                        estado_d = PRESIONADO;
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_ULTIMO) begin
                        estado_d = SUELTO;
                        cnt_d    = '0;
                        lanzar_d = 1'b0;
                    end else begin
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
                default: begin
                    estado_d = SUELTO;
                    cnt_d    = '0;
                    lanzar_d = 1'b0;
                end
            endcase
        end

        assign lanzar_po[g] = lanzar_q;
        assign pulso_po[g]  = pulso_q;
    end

endmodule
